// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub
//
// Pipelined carry-lookahead adder/subtractor for two's-complement operands.
// The WIDTH-bit word is split into N = WIDTH/BLOCK lookahead groups. Stage k
// evaluates group k with a flat two-level lookahead from its group carry-in,
// then registers:
//   - the sum bits produced so far;
//   - the operand bits the higher groups still need;
//   - the group carry-out;
//   - a valid bit.
// Every stage is elastic: it loads whenever it is empty or its downstream
// neighbour is taking its current contents.
//
// Parameters
//   WIDTH      operand/result width, multiple of BLOCK (default 20)
//   BLOCK      lookahead group size, >= 2 (default 5)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; drops all in-flight work
//   in_valid   operand word presented
//   in_ready   block can accept operands this cycle
//   a, b       two's-complement operands
//   sub        0: a+b, 1: a-b
//   out_valid  result word presented
//   out_ready  consumer takes the result this cycle
//   sum        result (registered)
//   carry      carry out of the MSB (for subtract, 1 means no borrow)
//   overflow   signed overflow (carry into MSB xor carry out of MSB)
//
// Build option
//   ADDSUB_SATURATE_EN  when defined, the last stage clamps signed overflow to
//                       the most positive / most negative value. carry and
//                       overflow still report the raw result.
module pipelined_cla_addsub #(
    parameter int WIDTH = 20,
    parameter int BLOCK = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int N = WIDTH / BLOCK;

    // Every carry of a group as a sum of products of the group's P/G bits
    // and the group carry-in. Each product term is built independently, so
    // the result is a flat two-level network with no ripple between bits.
    // Bit i of the result is the carry into bit i; bit BLOCK is the group
    // carry-out.
    function automatic logic [BLOCK:0] group_carries(
        input logic [BLOCK-1:0] p,
        input logic [BLOCK-1:0] g,
        input logic             cin
    );
        logic [BLOCK:0] c;
        logic           term;
        c    = '0;
        term = 1'b0;
        for (int i = 0; i <= BLOCK; i++) begin
            term = cin;
            for (int m = 0; m < i; m++) begin
                term = term & p[m];
            end
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) begin
                    term = term & p[m];
                end
                c[i] = c[i] | term;
            end
        end
        return c;
    endfunction

    // Per-stage pipeline state. The sub bit is folded into bp (B') and the
    // stage-0 carry-in, so it is not carried down the pipe.
    logic [WIDTH-1:0] sum_q [N];
    logic [WIDTH-1:0] sum_d [N];
    logic [WIDTH-1:0] a_q   [N];
    logic [WIDTH-1:0] a_d   [N];
    logic [WIDTH-1:0] bp_q  [N];
    logic [WIDTH-1:0] bp_d  [N];
    logic [N-1:0]     carry_q;
    logic [N-1:0]     carry_d;
    logic [N-1:0]     valid_q;
    logic [N-1:0]     valid_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [N:0]       ready_s;

    // Ready chain: a stage can load if it is empty or its contents move on.
    always_comb begin
        ready_s    = '0;
        ready_s[N] = out_ready;
        for (int k = N - 1; k >= 0; k--) begin
            ready_s[k] = ~valid_q[k] | ready_s[k+1];
        end
    end

    // Group evaluation and next-state selection for every stage.
    always_comb begin
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] bp_in;
        logic [WIDTH-1:0] sum_in;
        logic [WIDTH-1:0] sum_new;
        logic [WIDTH-1:0] last_sum;
        logic             cin;
        logic             v_in;
        logic             ovf_raw;
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] g;
        logic [BLOCK:0]   c;
        int               km1;

        a_in     = '0;
        bp_in    = '0;
        sum_in   = '0;
        sum_new  = '0;
        last_sum = '0;
        cin      = 1'b0;
        v_in     = 1'b0;
        ovf_raw  = 1'b0;
        p        = '0;
        g        = '0;
        c        = '0;
        km1      = 0;
        valid_d  = '0;
        carry_d  = '0;
        ovf_d    = 1'b0;

        for (int k = 0; k < N; k++) begin
            km1 = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                a_in   = a;
                bp_in  = sub ? ~b : b;
                cin    = sub;
                sum_in = '0;
                v_in   = in_valid;
            end else begin
                a_in   = a_q[km1];
                bp_in  = bp_q[km1];
                cin    = carry_q[km1];
                sum_in = sum_q[km1];
                v_in   = valid_q[km1];
            end

            p = a_in[k*BLOCK +: BLOCK] ^ bp_in[k*BLOCK +: BLOCK];
            g = a_in[k*BLOCK +: BLOCK] & bp_in[k*BLOCK +: BLOCK];
            c = group_carries(p, g, cin);

            sum_new                    = sum_in;
            sum_new[k*BLOCK +: BLOCK]  = p ^ c[BLOCK-1:0];

            sum_d[k]   = ready_s[k] ? sum_new    : sum_q[k];
            a_d[k]     = ready_s[k] ? a_in       : a_q[k];
            bp_d[k]    = ready_s[k] ? bp_in      : bp_q[k];
            carry_d[k] = ready_s[k] ? c[BLOCK]   : carry_q[k];
            valid_d[k] = ready_s[k] ? v_in       : valid_q[k];
        end

        // After the loop, c and sum_new still hold the last stage's values:
        // c[BLOCK-1] is the carry into the MSB, c[BLOCK] the carry out.
        ovf_raw = c[BLOCK] ^ c[BLOCK-1];
`ifdef ADDSUB_SATURATE_EN
        // Raw MSB 0 on overflow means the true result was negative.
        last_sum = ovf_raw ? {~sum_new[WIDTH-1], {(WIDTH-1){sum_new[WIDTH-1]}}}
                           : sum_new;
`else
        last_sum = sum_new;
`endif
        sum_d[N-1] = ready_s[N-1] ? last_sum : sum_q[N-1];
        ovf_d      = ready_s[N-1] ? ovf_raw  : ovf_q;
    end

    // Pipeline registers; reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                bp_q[k]  <= '0;
            end
            carry_q <= '0;
            valid_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                sum_q[k] <= sum_d[k];
                a_q[k]   <= a_d[k];
                bp_q[k]  <= bp_d[k];
            end
            carry_q <= carry_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = ready_s[0];
    assign out_valid = valid_q[N-1];
    assign sum       = sum_q[N-1];
    assign carry     = carry_q[N-1];
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed bench for pipelined_cla_addsub (WIDTH=20, BLOCK=5, four stages).
// Expected results for the boundary vectors are hand-computed constants; the
// back-to-back scenario uses a behavioural add/sub model.
module tb_pipelined_cla_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] a;
    logic [19:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] sum;
    logic        carry;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    pipelined_cla_addsub #(.WIDTH(20), .BLOCK(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Behavioural reference: returns {overflow, carry, sum}.
    function automatic logic [21:0] model(input logic [19:0] ma, input logic [19:0] mb,
                                          input logic ms);
        logic [19:0] bp;
        logic [20:0] full;
        logic [19:0] s;
        logic        o;
        bp   = ms ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bp} + {20'd0, ms};
        s    = full[19:0];
        o    = (ma[19] == bp[19]) && (s[19] != ma[19]);
`ifdef ADDSUB_SATURATE_EN
        if (o) s = ma[19] ? 20'h80000 : 20'h7FFFF;
`endif
        return {o, full[20], s};
    endfunction

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 20'h0;
        b         = 20'h0;
        sub       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        if (out_valid !== 1'b0) n_err++;
        n_vec++; if (sum !== 20'h0) begin n_err++; $display("FAIL reset_sum: got %h expected 00000", sum); end
        n_vec++; if (carry !== 1'b0) begin n_err++; $display("FAIL reset_carry: got %b expected 0", carry); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    // One operation through an idle pipe, checking latency and result.
    task automatic test_vector(input string name, input logic [19:0] va, input logic [19:0] vb,
                               input logic vs, input logic [19:0] es, input logic ec,
                               input logic eo);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = va;
        b         = vb;
        sub       = vs;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 20'h0;
        b        = 20'h0;
        sub      = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL %s_early_valid: cycle %0d got %b expected 0", name, i, out_valid);
            end
        end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL %s_out_valid: got %b expected 1", name, out_valid); end
        n_vec++; if (sum !== es) begin n_err++; $display("FAIL %s_sum: got %h expected %h", name, sum, es); end
        n_vec++; if (carry !== ec) begin n_err++; $display("FAIL %s_carry: got %b expected %b", name, carry, ec); end
        n_vec++; if (overflow !== eo) begin n_err++; $display("FAIL %s_overflow: got %b expected %b", name, overflow, eo); end
    endtask

    task automatic test_boundaries();
        test_vector("plus_neg1", 20'h00001, 20'hFFFFF, 1'b0, 20'h00000, 1'b1, 1'b0);
        test_vector("full_prop", 20'hFFFFF, 20'hFFFFF, 1'b1, 20'h00000, 1'b1, 1'b0);
`ifdef ADDSUB_SATURATE_EN
        test_vector("pos_ovf", 20'h7FFFF, 20'hFFFFF, 1'b1, 20'h7FFFF, 1'b0, 1'b1);
        test_vector("neg_ovf", 20'h80000, 20'h80000, 1'b0, 20'h80000, 1'b1, 1'b1);
`else
        test_vector("pos_ovf", 20'h7FFFF, 20'hFFFFF, 1'b1, 20'h80000, 1'b0, 1'b1);
        test_vector("neg_ovf", 20'h80000, 20'h80000, 1'b0, 20'h00000, 1'b1, 1'b1);
`endif
        test_vector("small_sub", 20'h00007, 20'h00008, 1'b1, 20'hFFFFF, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [19:0] ta [8];
        logic [19:0] tb [8];
        logic        ts [8];
        logic [21:0] expq [$];
        logic [21:0] exp_v;
        logic [19:0] prev_sum;
        logic        prev_hold;
        logic        saw_full;
        int          sent;
        int          got;
        int          occ;
        prev_sum  = 20'h0;
        prev_hold = 1'b0;
        saw_full  = 1'b0;
        sent      = 0;
        got       = 0;
        occ       = 0;
        for (int i = 0; i < 8; i++) begin
            ta[i] = 20'($urandom);
            tb[i] = 20'($urandom);
            ts[i] = i[0];
        end
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 6);
            if (sent < 8) begin
                in_valid = 1'b1;
                a        = ta[sent];
                b        = tb[sent];
                sub      = ts[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (prev_hold) begin
                n_vec++;
                if (sum !== prev_sum) begin
                    n_err++;
                    $display("FAIL b2b_hold: got %h expected %h", sum, prev_sum);
                end
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (expq.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_extra: got result %h expected none", sum);
                end else begin
                    exp_v = expq.pop_front();
                    if ({overflow, carry, sum} !== exp_v) begin
                        n_err++;
                        $display("FAIL b2b_result%0d: got %h expected %h", got,
                                 {overflow, carry, sum}, exp_v);
                    end
                end
                got++;
                occ--;
            end
            if (in_valid && !in_ready) begin
                n_vec++;
                saw_full = 1'b1;
                if (occ !== 4) begin
                    n_err++;
                    $display("FAIL b2b_stall_occ: got %0d held expected 4", occ);
                end
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(a, b, sub));
                sent++;
                occ++;
            end
            prev_hold = out_valid && !out_ready;
            prev_sum  = sum;
            @(posedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_vec++; if (got !== 8) begin n_err++; $display("FAIL b2b_count: got %0d expected 8", got); end
        n_vec++; if (saw_full !== 1'b1) begin n_err++; $display("FAIL b2b_backpressure: got %b expected 1", saw_full); end
        repeat (3) @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_duplicate: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 20'(2 * i + 1);
            b        = 20'(2 * i + 2);
            sub      = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        a        = 20'h0;
        b        = 20'h0;
        @(posedge clk);
        #2;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid: got %b expected 1", out_valid); end
        n_vec++; if (sum !== 20'h00003) begin n_err++; $display("FAIL rst_pre_sum: got %h expected 00003", sum); end
        rst = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid: got %b expected 0", out_valid); end
        n_vec++; if (sum !== 20'h0) begin n_err++; $display("FAIL rst_async_sum: got %h expected 00000", sum); end
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rst_stale: cycle %0d got %b expected 0", i, out_valid);
            end
        end
        test_vector("post_rst", 20'h00007, 20'h00008, 1'b1, 20'hFFFFF, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_boundaries();
        test_back_to_back();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
